fetch: RTL and testbench
========================

# fetch

Instruction-fetch stage sitting directly downstream of the PC register. It takes the current `pc`, issues in-order instruction-memory reads, buffers the returned words with their PCs in a small in-order queue, and hands `{pc, inst, exc}` to decode over a valid/ready handshake. It computes the `next_pc` fed back into the PC register, covering sequential advance, hold on stall, and redirect from branch or exception.

## Interface
- `DEPTH`, 4: queue entries and the maximum number of in-flight requests; power of two, ≥2.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `pc`  in  `ADDR_BUS` (32)  current PC from the PC register.
- `next_pc`  out  32  PC register input (combinational).
- `redirect`  in  1  flush and redirect request from the branch or exception unit.
- `redirect_pc`  in  32  redirect target.
- `rom_en`  out  1  memory read request.
- `rom_addr`  out  32  request address; equals `pc`.
- `rom_ready`  in  1  memory accepts the request this cycle.
- `rom_rvalid`  in  1  read data returned; responses arrive in order.
- `rom_rdata`  in  `DATA_BUS` (32)  instruction word.
- `out_valid`  out  1  head entry available to decode.
- `out_ready`  in  1  decode accepts the head entry.
- `out_pc`  out  32  PC of the head entry.
- `out_inst`  out  32  instruction of the head entry; 0 when `out_exc` is set.
- `out_exc`  out  1  instruction-address-misaligned flag.

## Operation
- Queue is a circular buffer of `DEPTH` entries, each `{pc, inst, exc, filled}`, with head/tail pointers and a `count`.
- Request condition: `rom_en = rst & !redirect & !halt & count<DEPTH & discard==0 & pc[1:0]==0`.
- Request accept (`rom_en & rom_ready`):
  - allocates the tail entry `{pc, filled=0}`;
  - `outstanding` increments;
  - `next_pc = pc+4`, 32-bit wrap, so 0xFFFFFFFC becomes 0x00000000.
- No accept: `next_pc = pc` (hold).
- Misaligned `pc` (`pc[1:0]!=0`), no redirect, `count<DEPTH`, `!halt`, `discard==0`:
  - allocates an entry `{pc, inst=0, exc=1, filled=1}` with no memory request;
  - sets `halt`;
  - `next_pc = pc`.
- `halt` blocks all further allocation until `redirect`.
- Response (`rom_rvalid`): `outstanding` decrements.
  - `discard>0`: word is dropped and `discard` decrements.
  - Otherwise: writes `rom_rdata` into the oldest unfilled entry and sets `filled`.
- `out_valid = (count>0) & head.filled & !redirect`. The head pops on `out_valid & out_ready`.
- `redirect` (highest priority):
  - `next_pc = redirect_pc`;
  - queue is emptied (`count=0`, pointers reset);
  - `halt` clears;
  - `discard` loads `outstanding` minus this cycle's response (`rom_rvalid`);
  - no request is issued and no pop occurs.
- Counter widths: `count`, `outstanding` and `discard` are `$clog2(DEPTH)+1` bits. The invariant `outstanding ≤ DEPTH` holds by construction.

## Timing
- Reset (`rst==0` at an edge): `count=0`, `outstanding=0`, `discard=0`, `halt=0`, pointers 0.
  - `out_valid=0`, `rom_en=0`, `out_pc/out_inst/out_exc=0`.
  - `next_pc` still tracks its equation, but the PC register resets itself to `INIT_PC`.
- Reset mid-operation discards all state. Responses to requests issued before reset are not tracked; the memory is reset on the same signal.
- `rom_en`, `rom_addr` and `next_pc` are combinational from `pc`, `redirect` and state. The accept in cycle N puts `pc+4` into the PC register at edge N+1.
- Response in cycle N → entry filled at edge N+1 → `out_valid` can be high in cycle N+1. There is no same-cycle bypass.
- Misaligned entry is visible at `out_valid` in the cycle after allocation.
- Same-cycle push and pop: `count` is unchanged. A full queue with a pop in the same cycle does not allow a request in that cycle, because `count<DEPTH` is evaluated before the pop.
- Redirect and response in the same cycle: the response is dropped and is not counted in `discard`.
- Redirect and `out_ready` in the same cycle: no pop; the entry is flushed.
- First request after a redirect is issued in the first cycle where `discard==0`.

## Structure
- `ADDR_BUS`, `DATA_BUS` and `INIT_PC` come from the shared `bus.v` and `exception.v` headers; the misaligned-fetch cause code belongs in `exception.v`.
- One sub-module: `fetch_queue`, the `DEPTH`-entry circular buffer with allocate, fill, pop and flush ports. The top level holds the `next_pc` mux, the `outstanding`/`discard` counters and `halt`.

## Test plan
- Reset, then `pc=0xBFC00000`, `rom_ready=1`, data returned 1 cycle later → `rom_addr` sequence 0xBFC00000, …04, …08; `out_inst` matches in order; `out_valid` first high 2 cycles after the first request.
- `out_ready=0` with `DEPTH=4` → exactly 4 accepted requests, then `rom_en=0` and `next_pc==pc`. Raise `out_ready` → one new request per pop.
- 3 requests in flight, `redirect=1`, `redirect_pc=0x80000100` → `next_pc=0x80000100`, `out_valid=0`, the 3 late responses are dropped, and the first new request is at 0x80000100.
- `pc=0x00000102` → no `rom_en`; one entry `{out_pc=0x102, out_exc=1, out_inst=0}`; fetch stays halted until a redirect to 0x200 resumes it.
- `pc=0xFFFFFFFC` accepted → `next_pc=0x00000000`.
- `rst` low for 1 cycle with 2 entries queued → next cycle `out_valid=0`, `rom_en` governed by an empty queue.

Source files
------------

// File: rtl/fetch_pkg.sv
// +----------------------------------------------------------------------------+
// | fetch_pkg                                                                  |
// | Shared bus widths, reset PC, fetch exception cause and queue entry type.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

    localparam int c_ADDR_BUS = 32;
    localparam int c_DATA_BUS = 32;

    localparam logic [c_ADDR_BUS-1:0] c_INIT_PC = 32'hBFC0_0000;

    // Cause code reported for an instruction-address-misaligned fetch.
    localparam logic [3:0] c_EXC_INST_MISALIGNED = 4'd0;

    typedef struct packed {
        logic [c_ADDR_BUS-1:0] pc;
        logic [c_DATA_BUS-1:0] inst;
        logic                  exc;
        logic                  filled;
    } fetch_entry_t;

    function automatic logic pc_misaligned(input logic [c_ADDR_BUS-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_if.sv
// +----------------------------------------------------------------------------+
// | fetch_if                                                                   |
// | PC feedback, instruction-memory and decode-side handshake of fetch.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fetch_if;
    import fetch_pkg::*;

    logic [c_ADDR_BUS-1:0] pc;
    logic [c_ADDR_BUS-1:0] next_pc;
    logic                  redirect;
    logic [c_ADDR_BUS-1:0] redirect_pc;
    logic                  rom_en;
    logic [c_ADDR_BUS-1:0] rom_addr;
    logic                  rom_ready;
    logic                  rom_rvalid;
    logic [c_DATA_BUS-1:0] rom_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [c_ADDR_BUS-1:0] out_pc;
    logic [c_DATA_BUS-1:0] out_inst;
    logic                  out_exc;

    modport master (
        input  pc, redirect, redirect_pc, rom_ready, rom_rvalid, rom_rdata, out_ready,
        output next_pc, rom_en, rom_addr, out_valid, out_pc, out_inst, out_exc
    );

    modport slave (
        output pc, redirect, redirect_pc, rom_ready, rom_rvalid, rom_rdata, out_ready,
        input  next_pc, rom_en, rom_addr, out_valid, out_pc, out_inst, out_exc
    );

endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
// +----------------------------------------------------------------------------+
// | fetch_queue                                                                |
// | In-order circular buffer of fetched words with allocate/fill/pop/flush.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         i_flush,
    input  wire logic                         i_alloc,
    input  wire logic [c_ADDR_BUS-1:0]        i_alloc_pc,
    input  wire logic                         i_alloc_exc,
    input  wire logic                         i_fill,
    input  wire logic [c_DATA_BUS-1:0]        i_fill_data,
    input  wire logic                         i_pop,
    output logic      [$clog2(DEPTH):0]       o_count,
    output fetch_entry_t                      o_head
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    fetch_entry_t       r_q [DEPTH];
    logic [c_PW-1:0]    r_head;
    logic [c_PW-1:0]    r_tail;
    logic [c_PW-1:0]    r_fill;
    logic [c_CW-1:0]    r_count;

    // r_fill tracks the oldest entry still waiting for its memory word; words
    // return in request order so it only ever advances.
    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_fill  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i].filled <= 1'b0;
            end
        end else begin
            if (i_alloc) begin
                r_q[r_tail].pc     <= i_alloc_pc;
                r_q[r_tail].inst   <= '0;
                r_q[r_tail].exc    <= i_alloc_exc;
                r_q[r_tail].filled <= i_alloc_exc;
                r_tail             <= r_tail + c_PW'(1);
            end
            if (i_fill) begin
                r_q[r_fill].inst   <= i_fill_data;
                r_q[r_fill].filled <= 1'b1;
                r_fill             <= r_fill + c_PW'(1);
            end
            if (i_pop) begin
                r_head <= r_head + c_PW'(1);
            end
            r_count <= r_count + c_CW'(i_alloc) - c_CW'(i_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_q[r_head] : '0;

endmodule

`default_nettype wire

// File: rtl/fetch.sv
// +----------------------------------------------------------------------------+
// | fetch                                                                      |
// | Instruction fetch: issues in-order reads, queues words, computes next_pc.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    fetch_if.master   bus
);

    localparam int               c_CW   = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0]  c_FULL = c_CW'(DEPTH);

    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_discard;
    logic            r_halt;

    logic [c_CW-1:0] w_count;
    fetch_entry_t    w_head;
    logic            w_can_alloc;
    logic            w_misaligned;
    logic            w_accept;
    logic            w_exc_alloc;
    logic            w_resp;
    logic            w_fill;
    logic            w_pop;

    assign w_misaligned = pc_misaligned(bus.pc);
    assign w_can_alloc  = rst && !bus.redirect && !r_halt
                          && (w_count < c_FULL) && (r_discard == '0);
    assign w_exc_alloc  = w_can_alloc && w_misaligned;
    assign bus.rom_en   = w_can_alloc && !w_misaligned;
    assign bus.rom_addr = bus.pc;
    assign w_accept     = bus.rom_en && bus.rom_ready;

    always_comb begin
        bus.next_pc = bus.pc;
        if (bus.redirect) begin
            bus.next_pc = bus.redirect_pc;
        end else if (w_accept) begin
            bus.next_pc = bus.pc + 32'd4;
        end
    end

    // A stray word with nothing outstanding (e.g. across reset) is ignored.
    assign w_resp = bus.rom_rvalid && (r_outstanding != '0);
    assign w_fill = w_resp && !bus.redirect && (r_discard == '0);

    assign bus.out_valid = (w_count != '0) && w_head.filled && !bus.redirect;
    assign w_pop         = bus.out_valid && bus.out_ready;
    assign bus.out_pc    = w_head.pc;
    assign bus.out_inst  = w_head.inst;
    assign bus.out_exc   = w_head.exc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_outstanding <= '0;
            r_discard     <= '0;
            r_halt        <= 1'b0;
        end else if (bus.redirect) begin
            // Words still in flight belong to the flushed path.
            r_outstanding <= r_outstanding - c_CW'(w_resp);
            r_discard     <= r_outstanding - c_CW'(w_resp);
            r_halt        <= 1'b0;
        end else begin
            r_outstanding <= r_outstanding + c_CW'(w_accept) - c_CW'(w_resp);
            if (w_resp && (r_discard != '0)) begin
                r_discard <= r_discard - c_CW'(1);
            end
            if (w_exc_alloc) begin
                r_halt <= 1'b1;
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (bus.redirect),
        .i_alloc     (w_accept || w_exc_alloc),
        .i_alloc_pc  (bus.pc),
        .i_alloc_exc (w_exc_alloc),
        .i_fill      (w_fill),
        .i_fill_data (bus.rom_rdata),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head      (w_head)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
// +----------------------------------------------------------------------------+
// | tb_fetch                                                                   |
// | Directed vector table plus hand-written sequences for fetch.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch;

    typedef struct {
        logic        rstn;
        logic [31:0] pc;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        ordy;
        logic        en;
        logic [31:0] npc;
        logic        ov;
        logic [31:0] opc;
        logic [31:0] oinst;
        logic        oexc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   auto_mem = 1'b0;
    vec_t vecs [19];

    always #5 clk = ~clk;

    fetch_if bus ();

    fetch #(
        .DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hFFFF_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: acts as PC register and, when enabled, a 1-cycle-latency memory.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        logic [31:0] np;
        acc = bus.rom_en & bus.rom_ready;
        a   = bus.rom_addr;
        np  = bus.next_pc;
        @(posedge clk);
        @(negedge clk);
        bus.pc = np;
        if (auto_mem) begin
            bus.rom_rvalid = acc;
            bus.rom_rdata  = inst_of(a);
        end
        #1;
    endtask

    initial begin
        int accepts;
        rst = 1'b0;
        bus.pc = 32'h0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
        bus.rom_ready = 1'b0; bus.rom_rvalid = 1'b0; bus.rom_rdata = 32'h0;
        bus.out_ready = 1'b0;

        //          rstn  pc            rd    rpc           rdy   rv    rdata         ordy  en    npc           ov    opc           oinst         oexc
        vecs[0]  = '{1'b0, 32'hBFC00000, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hBFC00000, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b1, 32'hBFC00000, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hBFC00004, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[2]  = '{1'b1, 32'hBFC00004, 1'b0, 32'h0,        1'b1, 1'b1, 32'h11111111, 1'b1, 1'b1, 32'hBFC00008, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'hBFC00008, 1'b0, 32'h0,        1'b1, 1'b1, 32'h22222222, 1'b1, 1'b1, 32'hBFC0000C, 1'b1, 32'hBFC00000, 32'h11111111, 1'b0};
        vecs[4]  = '{1'b1, 32'hBFC0000C, 1'b0, 32'h0,        1'b0, 1'b1, 32'h33333333, 1'b1, 1'b1, 32'hBFC0000C, 1'b1, 32'hBFC00004, 32'h22222222, 1'b0};
        vecs[5]  = '{1'b1, 32'hBFC0000C, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hBFC00010, 1'b1, 32'hBFC00008, 32'h33333333, 1'b0};
        vecs[6]  = '{1'b1, 32'hBFC00010, 1'b0, 32'h0,        1'b0, 1'b1, 32'h44444444, 1'b1, 1'b1, 32'hBFC00010, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[7]  = '{1'b1, 32'hBFC00010, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hBFC00010, 1'b1, 32'hBFC0000C, 32'h44444444, 1'b0};
        vecs[8]  = '{1'b1, 32'hBFC00010, 1'b1, 32'h00000102, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00000102, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[9]  = '{1'b1, 32'h00000102, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00000102, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[10] = '{1'b1, 32'h00000102, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00000102, 1'b1, 32'h00000102, 32'h0,        1'b1};
        vecs[11] = '{1'b1, 32'h00000102, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00000102, 1'b1, 32'h00000102, 32'h0,        1'b1};
        vecs[12] = '{1'b1, 32'h00000102, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00000102, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[13] = '{1'b1, 32'h00000102, 1'b1, 32'h00000200, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00000200, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[14] = '{1'b1, 32'h00000200, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00000204, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[15] = '{1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00000000, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[16] = '{1'b1, 32'h00000000, 1'b0, 32'h0,        1'b0, 1'b1, 32'h55555555, 1'b1, 1'b1, 32'h00000000, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[17] = '{1'b1, 32'h00000000, 1'b0, 32'h0,        1'b0, 1'b1, 32'hAAAA5555, 1'b1, 1'b1, 32'h00000000, 1'b1, 32'h00000200, 32'h55555555, 1'b0};
        vecs[18] = '{1'b1, 32'h00000000, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00000000, 1'b1, 32'hFFFFFFFC, 32'hAAAA5555, 1'b0};

        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            rst             = vecs[i].rstn;
            bus.pc          = vecs[i].pc;
            bus.redirect    = vecs[i].redir;
            bus.redirect_pc = vecs[i].rpc;
            bus.rom_ready   = vecs[i].rdy;
            bus.rom_rvalid  = vecs[i].rv;
            bus.rom_rdata   = vecs[i].rdata;
            bus.out_ready   = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_rom_en", i),    32'(bus.rom_en),    32'(vecs[i].en));
            chk($sformatf("v%0d_next_pc", i),   bus.next_pc,        vecs[i].npc);
            chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
            if (vecs[i].ov || !vecs[i].rstn) begin
                chk($sformatf("v%0d_out_pc", i),   bus.out_pc,       vecs[i].opc);
                chk($sformatf("v%0d_out_inst", i), bus.out_inst,     vecs[i].oinst);
                chk($sformatf("v%0d_out_exc", i),  32'(bus.out_exc), 32'(vecs[i].oexc));
            end
            if (vecs[i].en) begin
                chk($sformatf("v%0d_rom_addr", i), bus.rom_addr, vecs[i].pc);
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Full queue with decode stalled, then one request per pop.
        bus.redirect = 1'b0; bus.rom_rvalid = 1'b0; bus.out_ready = 1'b0;
        bus.rom_ready = 1'b1; bus.pc = 32'h0000_1000; rst = 1'b0;
        #1;
        tick();
        rst = 1'b1;
        auto_mem = 1'b1;
        #1;
        accepts = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.rom_en) begin
                chk("full_rom_addr", bus.rom_addr, 32'h0000_1000 + 32'(4 * accepts));
                accepts++;
            end
            tick();
        end
        chk("full_accepts", 32'(accepts), 32'd4);
        chk("full_rom_en", 32'(bus.rom_en), 32'd0);
        chk("full_hold_pc", bus.next_pc, 32'h0000_1010);
        bus.out_ready = 1'b1;
        #1;
        chk("pop1_valid", 32'(bus.out_valid), 32'd1);
        chk("pop1_pc", bus.out_pc, 32'h0000_1000);
        chk("pop1_inst", bus.out_inst, inst_of(32'h0000_1000));
        chk("pop1_no_req", 32'(bus.rom_en), 32'd0);
        tick();
        chk("pop2_req", 32'(bus.rom_en), 32'd1);
        chk("pop2_addr", bus.rom_addr, 32'h0000_1010);
        chk("pop2_pc", bus.out_pc, 32'h0000_1004);
        tick();
        chk("pop3_req", 32'(bus.rom_en), 32'd1);
        chk("pop3_addr", bus.rom_addr, 32'h0000_1014);
        chk("pop3_pc", bus.out_pc, 32'h0000_1008);

        // Redirect with three requests in flight.
        auto_mem = 1'b0;
        bus.rom_rvalid = 1'b0; bus.out_ready = 1'b1; bus.rom_ready = 1'b1;
        rst = 1'b0; bus.pc = 32'h0000_4000;
        #1;
        tick();
        rst = 1'b1;
        #1;
        tick();
        tick();
        tick();
        chk("rd_pc_before", bus.pc, 32'h0000_400C);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h8000_0100;
        #1;
        chk("rd_next_pc", bus.next_pc, 32'h8000_0100);
        chk("rd_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rd_rom_en", 32'(bus.rom_en), 32'd0);
        tick();
        bus.redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.rom_rvalid = 1'b1;
            bus.rom_rdata = 32'hDEAD_BEEF;
            #1;
            chk($sformatf("rd_drop%0d_en", k), 32'(bus.rom_en), 32'd0);
            chk($sformatf("rd_drop%0d_valid", k), 32'(bus.out_valid), 32'd0);
            tick();
        end
        bus.rom_rvalid = 1'b0;
        #1;
        chk("rd_first_req", 32'(bus.rom_en), 32'd1);
        chk("rd_first_addr", bus.rom_addr, 32'h8000_0100);
        tick();
        bus.rom_rvalid = 1'b1;
        bus.rom_rdata = 32'h1234_5678;
        #1;
        chk("rd_no_bypass", 32'(bus.out_valid), 32'd0);
        tick();
        bus.rom_rvalid = 1'b0;
        #1;
        chk("rd_new_valid", 32'(bus.out_valid), 32'd1);
        chk("rd_new_pc", bus.out_pc, 32'h8000_0100);
        chk("rd_new_inst", bus.out_inst, 32'h1234_5678);

        // Reset with two filled entries queued.
        bus.out_ready = 1'b0; bus.rom_ready = 1'b1;
        rst = 1'b0; bus.pc = 32'h0000_6000;
        auto_mem = 1'b1;
        #1;
        tick();
        rst = 1'b1;
        #1;
        tick();
        tick();
        bus.rom_ready = 1'b0;
        #1;
        tick();
        chk("rs_queued_valid", 32'(bus.out_valid), 32'd1);
        chk("rs_queued_pc", bus.out_pc, 32'h0000_6000);
        rst = 1'b0;
        #1;
        chk("rs_low_rom_en", 32'(bus.rom_en), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("rs_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rs_out_pc", bus.out_pc, 32'h0);
        chk("rs_rom_en", 32'(bus.rom_en), 32'd1);
        chk("rs_rom_addr", bus.rom_addr, 32'h0000_6008);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
